// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the serial FIR engine.
// FSM encoding plus width derivations used by the top and the output stage.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Channel selects stay at least one bit wide even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Wide enough that LENGTH full-precision products can never overflow.
  function automatic int acc_width(input int w, input int cw, input int len);
    return w + cw + clog2(len);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of the accumulator.
// Zero latency; no handshake, output follows acc.
module fir_round_sat #(
  parameter int WIDTH     = 16,
  parameter int ACC_W     = 34,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [WIDTH-1:0] data,
  output logic                    sat
);

  localparam int HEAD = ACC_W - WIDTH + 2;
  localparam logic signed [ACC_W:0] MAX_V = {{HEAD{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{HEAD{1'b1}}, {(WIDTH-1){1'b0}}};

  // One guard bit so the rounding increment cannot wrap.
  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] r;

  assign acc_x = {acc[ACC_W-1], acc};

  if (OUT_SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    logic signed [ACC_W:0] sum;
    assign sum = acc_x + HALF;
    assign r   = sum >>> OUT_SHIFT;
  end else begin : g_pass
    assign r = acc_x;
  end

  always_comb begin
    data = r[WIDTH-1:0];
    sat  = 1'b0;
    if (r > MAX_V) begin
      data = {1'b0, {(WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (r < MIN_V) begin
      data = {1'b1, {(WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed multi-channel FIR, one MAC per cycle; result valid LENGTH cycles after accept.
// in_ready only in IDLE; result is held indefinitely until out_ready, then the engine returns to IDLE.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int LENGTH     = 100,
  parameter int CHANNELS   = 1,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [ch_width(CHANNELS)-1:0]   in_ch,
  input  logic                            coef_we,
  input  logic [clog2(LENGTH)-1:0]        coef_addr,
  input  logic [COEF_WIDTH-1:0]           coef_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [ch_width(CHANNELS)-1:0]   out_ch,
  output logic                            out_sat,
  output logic                            busy
);

  localparam int CH_W   = ch_width(CHANNELS);
  localparam int IDX_W  = clog2(LENGTH);
  localparam int ACC_W  = acc_width(WIDTH, COEF_WIDTH, LENGTH);
  localparam int PROD_W = WIDTH + COEF_WIDTH;
  localparam int DEPTH  = CHANNELS * LENGTH;
  localparam int DA_W   = ch_width(DEPTH);

  localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(CHANNELS);
  localparam logic [IDX_W:0]   LEN_LIM  = (IDX_W + 1)'(LENGTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LENGTH - 1);

  fir_state_t state_q, state_d;

  // Channel c occupies dly_q[c*LENGTH +: LENGTH], newest sample at the low index.
  logic signed [WIDTH-1:0]      dly_q  [DEPTH];
  logic signed [COEF_WIDTH-1:0] coef_q [LENGTH];
  logic        [IDX_W-1:0]      idx_q;
  logic        [CH_W-1:0]       ch_q;
  logic signed [ACC_W-1:0]      acc_q;

  logic                         in_fire;
  logic                         coef_fire;
  logic                         mac_last;
  logic        [DA_W-1:0]       rd_addr;
  logic signed [WIDTH-1:0]      x_sel;
  logic signed [COEF_WIDTH-1:0] h_sel;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      prod_ext;

  // Samples for nonexistent channels are swallowed without leaving IDLE.
  assign in_fire   = in_valid && (state_q == IDLE) && ({1'b0, in_ch} < CH_LIM);
  assign coef_fire = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < LEN_LIM);
  assign mac_last  = (idx_q == IDX_LAST);

  assign rd_addr  = DA_W'(int'(ch_q) * LENGTH + int'(idx_q));
  assign x_sel    = dly_q[rd_addr];
  assign h_sel    = coef_q[idx_q];
  assign prod     = PROD_W'(x_sel) * PROD_W'(h_sel);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = rst;
        busy     = 1'b0;
        if (in_fire) state_d = MAC;
      end
      MAC: begin
        if (mac_last) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
      for (int k = 0; k < LENGTH; k++) coef_q[k] <= '0;
      acc_q <= '0;
      idx_q <= '0;
      ch_q  <= '0;
    end else begin
      // The write lands before the MAC pass that a same-edge accept launches.
      if (coef_fire) coef_q[coef_addr] <= coef_data;
      if (in_fire) begin
        acc_q <= '0;
        idx_q <= '0;
        ch_q  <= in_ch;
        for (int c = 0; c < CHANNELS; c++) begin
          if (in_ch == CH_W'(c)) begin
            dly_q[c*LENGTH] <= in_data;
            for (int k = 1; k < LENGTH; k++) dly_q[c*LENGTH + k] <= dly_q[c*LENGTH + k - 1];
          end
        end
      end else if (state_q == MAC) begin
        acc_q <= acc_q + prod_ext;
        idx_q <= mac_last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  assign out_ch = ch_q;

  fir_round_sat #(
    .WIDTH    (WIDTH),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .acc (acc_q),
    .data(out_data),
    .sat (out_sat)
  );

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: a 3-channel unshifted instance and a 1-channel OUT_SHIFT=1
// instance run in lockstep on shared stimulus, checked against an arithmetic tap-sum model.
module tb_fir_mac_engine;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        coef_we = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] coef_data = '0;
  logic [1:0]  in_ch = '0;
  logic [1:0]  coef_addr = '0;
  logic        in_ready, out_valid, out_sat, busy;
  logic [15:0] out_data;
  logic [1:0]  out_ch;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic [15:0] b_out_data;
  logic [0:0]  b_out_ch;
  logic [0:0]  b_in_ch = 1'b0;

  int tests = 0;
  int fails = 0;

  int mh [L];
  int ma [3][L];
  int mb [L];

  always #5 clk = ~clk;

  // The single-channel instance only sees samples the 3-channel one would accept.
  assign b_in_valid = in_valid && (in_ch < 2'd3);

  fir_mac_engine #(
    .WIDTH(16), .COEF_WIDTH(16), .LENGTH(L), .CHANNELS(3), .OUT_SHIFT(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_sat(out_sat), .busy(busy)
  );

  fir_mac_engine #(
    .WIDTH(16), .COEF_WIDTH(16), .LENGTH(L), .CHANNELS(1), .OUT_SHIFT(1)
  ) u_dut_rnd (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ch(b_in_ch),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ch(b_out_ch), .out_sat(b_out_sat), .busy(b_busy)
  );

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int k = 0; k < L; k++) begin
      mh[k] = 0;
      mb[k] = 0;
      for (int c = 0; c < 3; c++) ma[c][k] = 0;
    end
  endfunction

  function automatic void model_push(input int ch, input int v);
    for (int k = L - 1; k > 0; k--) begin
      ma[ch][k] = ma[ch][k-1];
      mb[k]     = mb[k-1];
    end
    ma[ch][0] = v;
    mb[0]     = v;
  endfunction

  // ch < 0 selects the single-channel instance's history.
  function automatic longint model_dot(input int ch);
    longint s;
    s = 0;
    for (int k = 0; k < L; k++)
      s += longint'((ch < 0) ? mb[k] : ma[ch][k]) * longint'(mh[k]);
    return s;
  endfunction

  // Returns {sat, data}.
  function automatic logic [16:0] model_out(input longint acc, input int sh);
    longint r;
    r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
    if (r > 32767)  return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(r)};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 16'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    mh[a] = v;
  endtask

  task automatic send(input int ch, input int v, input bit we, input int wa, input int wd,
                      output int lat, output logic [15:0] da, output logic sa,
                      output logic [1:0] ca, output logic [15:0] db, output logic sb);
    int n;
    lat = -1;
    in_valid = 1'b1; in_ch = 2'(ch); in_data = 16'(v);
    coef_we = we; coef_addr = 2'(wa); coef_data = 16'(wd);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (we) mh[wa] = wd;
    if (ch < 3) model_push(ch, v);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (out_valid === 1'b1) lat = n;
    da = out_data; sa = out_sat; ca = out_ch; db = b_out_data; sb = b_out_sat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0 || b_in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_hold: in_ready=%b b_in_ready=%b out_valid=%b busy=%b want 0 0 0 0",
                        in_ready, b_in_ready, out_valid, busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, b_in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b/%b want 0/0", out_valid, b_out_valid);
    end
    tests++;
    if (out_data !== 16'h0000 || b_out_data !== 16'h0000) begin
      fails++; $display("FAIL reset_out_data: got %h/%h want 0000", out_data, b_out_data);
    end
    tests++;
    if (out_ch !== 2'd0 || out_sat !== 1'b0 || b_out_sat !== 1'b0 || b_out_ch !== 1'b0) begin
      fails++; $display("FAIL reset_ch_sat: ch=%0d sat=%b bsat=%b want 0 0 0", out_ch, out_sat, b_out_sat);
    end
    tests++;
    if (busy !== 1'b0 || b_busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, b_busy);
    end
    model_clear();
  endtask

  task automatic test_impulse();
    int imp_in [5] = '{1, 0, 0, 0, 0};
    logic [15:0] imp_exp [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca; logic [16:0] eb;
    for (int k = 0; k < L; k++) write_coef(k, k + 1);
    for (int i = 0; i < 5; i++) begin
      send(0, imp_in[i], 1'b0, 0, 0, lat, da, sa, ca, db, sb);
      eb = model_out(model_dot(-1), 1);
      tests++;
      if (lat !== 4) begin fails++; $display("FAIL impulse_latency[%0d]: got %0d want 4", i, lat); end
      tests++;
      if (da !== imp_exp[i] || sa !== 1'b0) begin
        fails++; $display("FAIL impulse_data[%0d]: got %h sat %b want %h sat 0", i, da, sa, imp_exp[i]);
      end
      tests++;
      if (db !== eb[15:0] || sb !== eb[16]) begin
        fails++; $display("FAIL impulse_rnd[%0d]: got %h sat %b want %h sat %b", i, db, sb, eb[15:0], eb[16]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca; logic [16:0] ea;
    for (int k = 0; k < L; k++) write_coef(k, 32767);
    for (int i = 0; i < 8; i++) begin
      send(0, (i < 4) ? 32767 : -32768, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
      ea = model_out(model_dot(0), 0);
      tests++;
      if (da !== ea[15:0] || sa !== ea[16]) begin
        fails++; $display("FAIL sat_model[%0d]: got %h sat %b want %h sat %b", i, da, sa, ea[15:0], ea[16]);
      end
      if (i == 3) begin
        tests++;
        if (da !== 16'h7fff || sa !== 1'b1) begin
          fails++; $display("FAIL sat_pos: got %h sat %b want 7fff sat 1", da, sa);
        end
      end
      if (i == 7) begin
        tests++;
        if (da !== 16'h8000 || sa !== 1'b1) begin
          fails++; $display("FAIL sat_neg: got %h sat %b want 8000 sat 1", da, sa);
        end
      end
    end
  endtask

  task automatic test_channels();
    int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca;
    int          c_ch  [5] = '{0, 1, 0, 0, 1};
    int          c_in  [5] = '{1, 5, 0, 0, 0};
    logic [15:0] c_exp [5] = '{16'd1, 16'd5, 16'd2, 16'd3, 16'd10};
    for (int i = 0; i < L; i++) send(0, 0, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
    for (int k = 0; k < L; k++) write_coef(k, k + 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        send(3, 77, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
        tests++;
        if (lat !== -1 || in_ready !== 1'b1 || busy !== 1'b0) begin
          fails++; $display("FAIL chan_drop: lat=%0d in_ready=%b busy=%b want -1 1 0", lat, in_ready, busy);
        end
      end
      send(c_ch[i], c_in[i], 1'b0, 0, 0, lat, da, sa, ca, db, sb);
      tests++;
      if (da !== c_exp[i] || ca !== 2'(c_ch[i])) begin
        fails++; $display("FAIL chan_result[%0d]: got %0d ch %0d want %0d ch %0d", i, da, ca, c_exp[i], c_ch[i]);
      end
    end
  endtask

  task automatic test_rounding();
    int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca;
    write_coef(0, 3);
    for (int k = 1; k < L; k++) write_coef(k, 0);
    send(0, 1, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
    tests++;
    if (db !== 16'd2 || sb !== 1'b0) begin
      fails++; $display("FAIL round_pos: got %h sat %b want 0002 sat 0", db, sb);
    end
    for (int i = 0; i < 3; i++) send(0, 0, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
    send(0, -1, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
    tests++;
    if (db !== 16'hffff || sb !== 1'b0) begin
      fails++; $display("FAIL round_neg: got %h sat %b want ffff sat 0", db, sb);
    end
    tests++;
    if (da !== 16'hfffd) begin
      fails++; $display("FAIL round_unshifted: got %h want fffd", da);
    end
  endtask

  task automatic test_backpressure();
    int n; int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca; logic [16:0] ea;
    write_coef(0, 1); write_coef(1, -2); write_coef(2, 3); write_coef(3, -4);
    in_valid = 1'b1; in_ch = 2'd2; in_data = 16'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(2, 1000);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'h1234;
    @(posedge clk); #1;
    coef_we = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    ea = model_out(model_dot(2), 0);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin coef_we = 1'b1; coef_addr = 2'd1; coef_data = 16'h4321; end
      @(posedge clk); #1;
      coef_we = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== ea[15:0]) begin
        fails++; $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b busy=%b data=%h want 1 0 1 %h",
                          i, out_valid, in_ready, busy, out_data, ea[15:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: in_ready=%b busy=%b valid=%b want 1 0 0", in_ready, busy, out_valid);
    end
    send(2, 1000, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
    ea = model_out(model_dot(2), 0);
    tests++;
    if (da !== ea[15:0] || ca !== 2'd2) begin
      fails++; $display("FAIL bp_rerun: got %h ch %0d want %h ch 2", da, ca, ea[15:0]);
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca; logic [16:0] ea, eb;
    for (int k = 0; k < L; k++) write_coef(k, int'($urandom_range(0, 16)) - 8);
    for (int i = 0; i < 40; i++) begin
      int ch, v, wa, wd;
      bit we;
      ch = int'($urandom_range(0, 2));
      v  = (i % 5 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 6000)) - 3000;
      we = ($urandom_range(0, 3) == 0);
      wa = int'($urandom_range(0, 3));
      wd = (i % 7 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16)) - 8;
      send(ch, v, we, wa, wd, lat, da, sa, ca, db, sb);
      ea = model_out(model_dot(ch), 0);
      eb = model_out(model_dot(-1), 1);
      tests++;
      if (lat !== 4 || ca !== 2'(ch)) begin
        fails++; $display("FAIL rand_lat_ch[%0d]: lat %0d ch %0d want 4 ch %0d", i, lat, ca, ch);
      end
      tests++;
      if (da !== ea[15:0] || sa !== ea[16]) begin
        fails++; $display("FAIL rand_data[%0d]: got %h sat %b want %h sat %b", i, da, sa, ea[15:0], ea[16]);
      end
      tests++;
      if (db !== eb[15:0] || sb !== eb[16] || b_out_ch !== 1'b0) begin
        fails++; $display("FAIL rand_rnd[%0d]: got %h sat %b want %h sat %b", i, db, sb, eb[15:0], eb[16]);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    int lat; logic [15:0] da, db; logic sa, sb; logic [1:0] ca;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || b_out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_assert: valid=%b in_ready=%b bvalid=%b busy=%b want 0 0 0 0",
                        out_valid, in_ready, b_out_valid, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL midrst_release[%0d]: valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
    send(0, 1, 1'b0, 0, 0, lat, da, sa, ca, db, sb);
    tests++;
    if (lat !== 4 || da !== 16'h0000 || db !== 16'h0000) begin
      fails++; $display("FAIL midrst_impulse: lat %0d data %h/%h want 4 0000/0000", lat, da, db);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_channels();
    test_rounding();
    test_backpressure();
    test_random();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
Parametrised, time-multiplexed serial FIR engine. It succeeds the single-channel fixed-ROM datapath and adds:
- CHANNELS independent delay lines;
- a runtime-writable coefficient memory;
- valid/ready handshakes on input and output;
- round-and-saturate output stage.
It sits between the sample source and the downstream consumer. One multiply-accumulate (MAC) runs per cycle.

Parameters:
WIDTH, 16, sample and output word width (signed)
COEF_WIDTH, 16, coefficient width (signed)
LENGTH, 100, number of taps (>=2)
CHANNELS, 1, independent channels sharing the coefficient set (>=1)
OUT_SHIFT, 0, arithmetic right shift applied to accumulator before saturation (0..ACC_W-WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  sample offered
in_ready  out  1  engine can accept a sample
in_data  in  WIDTH  signed sample
in_ch  in  max(1,clog2(CHANNELS))  channel of sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(LENGTH)  tap index
coef_data  in  COEF_WIDTH  signed coefficient
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  rounded, saturated result
out_ch  out  max(1,clog2(CHANNELS))  channel of result
out_sat  out  1  saturation occurred on this result
busy  out  1  state != IDLE

Behaviour:
- ACC_W = WIDTH + COEF_WIDTH + clog2(LENGTH). Products are full-precision signed, sign-extended to ACC_W. The accumulator never overflows.
- Reset (rst=0, async):
  - state=IDLE; all delay lines and coefficients = 0; acc = 0; tap index = 0.
  - in_ready=1 once rst deasserts; out_valid=0; out_data=0; out_ch=0; out_sat=0; busy=0.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: channel in_ch delay line shifts (x[k] <- x[k-1], x[0] <- in_data), acc <- 0, idx <- 0, out_ch latched, state -> MAC.
  - in_ch >= CHANNELS: the sample is dropped, there is no state change, and in_ready stays 1.
- MAC:
  - in_ready=0.
  - Edges T+1..T+LENGTH: acc <- acc + x_ch[idx]*h[idx]; idx increments.
  - At the edge where idx==LENGTH-1: idx <- 0, state -> OUT.
- OUT:
  - out_valid=1 from after edge T+LENGTH.
  - out_data/out_ch/out_sat are stable while out_valid=1 and out_ready=0; hold is unbounded.
  - On out_valid&out_ready: state -> IDLE. in_ready=1 the following cycle; input and output handshakes never overlap.
- Latency: accept edge T to out_valid high after edge T+LENGTH. Minimum sample period is LENGTH+2 cycles.
- Round/saturate (combinational from acc):
  - If OUT_SHIFT>0, r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT; otherwise r = acc.
  - If r > 2^(WIDTH-1)-1, out_data = 0x7FF..F. If r < -2^(WIDTH-1), out_data = 0x80..0. In both cases out_sat=1.
  - Otherwise out_data = r[WIDTH-1:0] and out_sat=0.
- Coefficient write:
  - Accepted only in IDLE; h[coef_addr] <- coef_data at the edge.
  - Ignored in MAC/OUT and when coef_addr >= LENGTH.
  - A simultaneous coef_we and input accept in IDLE: the write lands first, so the new coefficient is used by that MAC.
- Reset asserted mid-MAC or mid-OUT aborts immediately. No partial output is ever presented.
- Delay lines of channels not addressed are never modified.

Decomposition:
- Shared package fir_pkg:
  - state encoding localparams (IDLE, MAC, OUT);
  - clog2 function;
  - ACC_W derivation function.
- One sub-module, fir_round_sat: purely combinational round + saturate. Parameters WIDTH, ACC_W, OUT_SHIFT. Ports acc in, data/sat out.
- Delay storage is a CHANNELS*LENGTH register array inside fir_mac_engine. Coefficient storage is a LENGTH register array.

Test Plan:
1. Impulse: LENGTH=4, CHANNELS=1, OUT_SHIFT=0, h={1,2,3,4}. Inputs 1,0,0,0,0 -> out_data 1,2,3,4,0. out_valid rises exactly 4 cycles after each accept.
2. Saturation: LENGTH=4, all h=0x7FFF. Four inputs 0x7FFF -> final output 0x7FFF with out_sat=1. Four inputs 0x8000 with all h=0x7FFF -> 0x8000 with out_sat=1.
3. Rounding: OUT_SHIFT=1, h={3,0,0,0}. Input 1 -> out_data 2. Input -1 (after zero flush) -> out_data -1.
4. Channel isolation: CHANNELS=2, impulse h={1,2,3,4}. Input ch0=1 then ch1=5, then ch0=0 -> results ch0:1, ch1:5, ch0:2, with out_ch matching each result.
5. Backpressure/coef guard: hold out_ready=0 for 10 cycles -> out_data held, in_ready=0, busy=1. A coef_we during MAC leaves h unchanged; a re-run gives the identical result.
6. Reset mid-MAC: assert rst at cycle 2 of MAC -> out_valid=0 and in_ready=0 during reset, in_ready=1 after release. Next impulse yields 0, because coefficients reset to 0.
